duck_sprite_engine: RTL and testbench

//  Upstream stage of vga_bitchange: owns the player duck (position, jump physics, walk animation).

---
 rtl/duck_sprite_engine_pkg.sv | 27 ++
 rtl/duck_sprite_engine_if.sv | 17 +
 rtl/duck_sprite_engine_rom.sv | 41 ++++
 rtl/duck_sprite_engine.sv | 166 ++++++++++++++++
 tb/tb_duck_sprite_engine.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/duck_sprite_engine_pkg.sv
// Shared definitions for the duck sprite engine: colour-index codes,
// 800x525 raster timing, the visible window and the jump FSM states.
package duck_sprite_engine_pkg;

   // Colour-index codes understood by vga_bitchange
   localparam logic [3:0] CI_TRANSP = 4'd0;
   localparam logic [3:0] CI_BG     = 4'd1;
   localparam logic [3:0] CI_O      = 4'd2;
   localparam logic [3:0] CI_Y      = 4'd3;
   localparam logic [3:0] CI_W      = 4'd4;
   localparam logic [3:0] CI_K      = 4'd5;
   localparam logic [3:0] CI_G      = 4'd6;
   localparam logic [3:0] CI_B      = 4'd7;
   localparam logic [3:0] CI_TEXT   = 4'd8;

   // 800x525 raster timing and visible window
   localparam int H_TOTAL     = 800;
   localparam int V_TOTAL     = 525;
   localparam int H_VIS_START = 144;
   localparam int H_VIS_END   = 783;
   localparam int V_VIS_START = 35;
   localparam int V_VIS_END   = 514;

   // Jump state machine
   typedef enum logic [1:0] {IDLE, RISE, FALL} duck_state_e;

endpackage

// File: rtl/duck_sprite_engine_if.sv
// Raster-in / sprite-out bundle between the raster source and the engine.
interface duck_sprite_engine_if #(
   parameter int CIDXW = 3
);
   logic             button;
   logic [9:0]       hCount;
   logic [9:0]       vCount;
   logic             spr_drawing;
   logic [CIDXW:0]   spr_indx;
   logic [9:0]       duck_y;
   logic             airborne;

   modport master (output button, hCount, vCount,
                   input  spr_drawing, spr_indx, duck_y, airborne);
   modport slave  (input  button, hCount, vCount,
                   output spr_drawing, spr_indx, duck_y, airborne);
endinterface

// File: rtl/duck_sprite_engine_rom.sv
// Duck artwork: 2 frames x 32x32 texels x colour index, synchronous read.
// The art is generated by a constant texel function so no external image
// file is needed: body colour differs per walk frame, the beak band sits on
// the right edge and the corner above it is transparent.
module duck_sprite_rom
   import duck_sprite_engine_pkg::*;
#(
   parameter int CIDXW = 3
) (
   input  logic             clk,
   input  logic [10:0]      addr_i,
   output logic [CIDXW:0]   data_o
);

   function automatic logic [CIDXW:0] texel(input logic [10:0] a);
      logic       frame;
      logic [4:0] row;
      logic [4:0] col;
      frame = a[10];
      row   = a[9:5];
      col   = a[4:0];
      if (col >= 5'd24 && row < 5'd8)
         texel = (CIDXW+1)'(CI_TRANSP);
      else if (col >= 5'd24 && row < 5'd16)
         texel = (CIDXW+1)'(CI_W);
      else if (frame)
         texel = (CIDXW+1)'(CI_Y);
      else
         texel = (CIDXW+1)'(CI_O);
   endfunction

   logic [CIDXW:0] data_q;

   // Registered ROM read
   always_ff @(posedge clk) begin
      data_q <= texel(addr_i);
   end

   assign data_o = data_q;

endmodule

// File: rtl/duck_sprite_engine.sv
// Player duck: button edge detect, frame-rate jump physics, walk animation
// and a 2-stage pixel pipeline that looks 2 columns ahead so its output
// lines up with the hCount/vCount presented in the same cycle.
module duck_sprite_engine
   import duck_sprite_engine_pkg::*;
#(
   parameter int CIDXW      = 3,
   parameter int DUCK_X     = 200,
   parameter int GROUND_Y   = 400,
   parameter int SPR_W      = 32,
   parameter int JUMP_V     = 12,
   parameter int GRAV       = 1,
   parameter int ANIM_FR    = 8,
   parameter int FRAME_LINE = 515
) (
   input  logic                  clk,
   input  logic                  reset_n,
   duck_sprite_engine_if.slave   bus
);

   localparam int ACW = (ANIM_FR > 1) ? $clog2(ANIM_FR) : 1;

   // The apex must stay on screen, the address packing assumes a 32x32
   // sprite and the launch speed must fit the 5-bit velocity register.
   if (JUMP_V*(JUMP_V+1)/2 >= GROUND_Y || SPR_W != 32 || JUMP_V > 31 ||
       DUCK_X < 144 || DUCK_X > 784-SPR_W) begin : g_param_check
      $error("duck_sprite_engine: illegal parameter combination");
   end

   duck_state_e     state_q, state_d;
   logic [4:0]      vel_q, vel_d;
   logic [9:0]      duck_y_q, duck_y_d;
   logic            anim_q, anim_d;
   logic [ACW-1:0]  anim_cnt_q, anim_cnt_d;
   logic            btn_q;
   logic            jump_req_q, jump_req_d;

   logic            frame_tick;
   logic            press;
   logic [4:0]      vel_dec, vel_inc;
   logic [10:0]     fall_sum;

   assign frame_tick = (bus.vCount == 10'(FRAME_LINE)) && (bus.hCount == 10'd0);
   assign press      = bus.button & ~btn_q;
   assign vel_dec    = vel_q - 5'(GRAV);
   assign vel_inc    = vel_q + 5'(GRAV);
   assign fall_sum   = {1'b0, duck_y_q} + {6'b0, vel_inc};

   // Next-state and physics, evaluated once per frame tick
   always_comb begin
      state_d    = state_q;
      vel_d      = vel_q;
      duck_y_d   = duck_y_q;
      anim_d     = anim_q;
      anim_cnt_d = anim_cnt_q;
      jump_req_d = jump_req_q | (press && state_q == IDLE);
      if (frame_tick) begin
         // The tick consumes the pending request; a press in this same
         // clock is kept for the next tick only if we stay on the ground.
         jump_req_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (jump_req_q) begin
                  state_d    = RISE;
                  vel_d      = 5'(JUMP_V);
                  anim_d     = 1'b0;
                  anim_cnt_d = '0;
               end else begin
                  jump_req_d = press;
                  if (anim_cnt_q == ACW'(ANIM_FR-1)) begin
                     anim_d     = ~anim_q;
                     anim_cnt_d = '0;
                  end else begin
                     anim_cnt_d = anim_cnt_q + 1'b1;
                  end
               end
            end
            RISE: begin
               duck_y_d = duck_y_q - {5'b0, vel_q};
               vel_d    = vel_dec;
               if (vel_dec == 5'd0) state_d = FALL;
            end
            FALL: begin
               if (fall_sum >= 11'(GROUND_Y)) begin
                  duck_y_d = 10'(GROUND_Y);
                  vel_d    = 5'd0;
                  state_d  = IDLE;
               end else begin
                  duck_y_d = fall_sum[9:0];
                  vel_d    = vel_inc;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control and physics state registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         vel_q      <= 5'd0;
         duck_y_q   <= 10'(GROUND_Y);
         anim_q     <= 1'b0;
         anim_cnt_q <= '0;
         btn_q      <= 1'b0;
         jump_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vel_q      <= vel_d;
         duck_y_q   <= duck_y_d;
         anim_q     <= anim_d;
         anim_cnt_q <= anim_cnt_d;
         btn_q      <= bus.button;
         jump_req_q <= jump_req_d;
      end
   end

   // ---- S0: look-ahead hit test and texel address ----
   logic [9:0]     h_la_p0, dx_p0, dy_p0;
   logic           hit_p0;
   logic [10:0]    rom_addr_p0;

   assign h_la_p0     = bus.hCount + 10'd2;
   assign dx_p0       = h_la_p0 - 10'(DUCK_X);
   assign dy_p0       = bus.vCount - duck_y_q;
   assign hit_p0      = (dx_p0 < 10'(SPR_W)) && (dy_p0 < 10'(SPR_W));
   assign rom_addr_p0 = {anim_q, dy_p0[4:0], dx_p0[4:0]};

   // ---- S1: ROM read, hit delayed alongside ----
   logic           hit_p1_q;
   logic [CIDXW:0] rom_data_p1;

   duck_sprite_rom #(.CIDXW(CIDXW)) u_rom (
      .clk    (clk),
      .addr_i (rom_addr_p0),
      .data_o (rom_data_p1)
   );

   // Hit flag follows the ROM read latency
   always_ff @(posedge clk) begin
      if (!reset_n) hit_p1_q <= 1'b0;
      else          hit_p1_q <= hit_p0;
   end

   // ---- S2: output register, index 0 is transparent ----
   logic           spr_drawing_q;
   logic [CIDXW:0] spr_indx_q;

   // Gate the texel with the hit flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         spr_drawing_q <= 1'b0;
         spr_indx_q    <= '0;
      end else begin
         spr_drawing_q <= hit_p1_q && (rom_data_p1 != '0);
         spr_indx_q    <= hit_p1_q ? rom_data_p1 : '0;
      end
   end

   assign bus.spr_drawing = spr_drawing_q;
   assign bus.spr_indx    = spr_indx_q;
   assign bus.duck_y      = duck_y_q;
   assign bus.airborne    = (state_q != IDLE);

endmodule

// File: tb/tb_duck_sprite_engine.sv
// Directed bench for duck_sprite_engine: a pixel vector table plus
// hand-written frame-tick sequences for jump, animation and reset cases.
module tb_duck_sprite_engine;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   duck_sprite_engine_if #(.CIDXW(3)) bus ();

   duck_sprite_engine dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         h;
      int         v;
      logic       draw;
      logic [3:0] idx;
   } pix_vec_t;

   pix_vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int h, input int v, input logic b);
      @(posedge clk);
      #1;
      bus.hCount = 10'(h);
      bus.vCount = 10'(v);
      bus.button = b;
   endtask

   task automatic park(input logic b);
      drive(10, 520, b);
      #3;
   endtask

   task automatic tick(input logic b);
      drive(0, 515, b);
      drive(10, 520, b);
      #3;
   endtask

   task automatic ticks(input int n, input logic b);
      repeat (n) tick(b);
   endtask

   task automatic press();
      park(1'b1);
      park(1'b0);
   endtask

   // Walk the raster up to (h,v) so the pipeline is primed, then sample
   task automatic pix(input string name, input int h, input int v,
                      input logic d, input logic [3:0] i);
      for (int k = 3; k >= 0; k--) drive(h - k, v, 1'b0);
      #3;
      chk({name, ".draw"}, 32'(bus.spr_drawing), 32'(d));
      chk({name, ".indx"}, 32'(bus.spr_indx), 32'(i));
   endtask

   initial begin
      bus.hCount = 10'd10;
      bus.vCount = 10'd520;
      bus.button = 1'b0;

      tbl[0]  = '{200, 400, 1'b1, 4'd2};   // texel (0,0)
      tbl[1]  = '{232, 400, 1'b0, 4'd0};   // one past right edge
      tbl[2]  = '{231, 400, 1'b0, 4'd0};   // transparent corner
      tbl[3]  = '{224, 400, 1'b0, 4'd0};   // transparent corner, left col
      tbl[4]  = '{223, 400, 1'b1, 4'd2};   // body next to corner
      tbl[5]  = '{224, 408, 1'b1, 4'd4};   // beak top-left
      tbl[6]  = '{231, 415, 1'b1, 4'd4};   // beak bottom-right
      tbl[7]  = '{224, 416, 1'b1, 4'd2};   // body under beak
      tbl[8]  = '{199, 400, 1'b0, 4'd0};   // one left of sprite
      tbl[9]  = '{200, 399, 1'b0, 4'd0};   // one row above
      tbl[10] = '{200, 431, 1'b1, 4'd2};   // last row
      tbl[11] = '{200, 432, 1'b0, 4'd0};   // one row below

      // Power-on reset
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      #3;
      chk("rst.duck_y", 32'(bus.duck_y), 32'd400);
      chk("rst.airborne", 32'(bus.airborne), 32'd0);
      chk("rst.draw", 32'(bus.spr_drawing), 32'd0);
      chk("rst.indx", 32'(bus.spr_indx), 32'd0);

      // Pixel table on the ground, walk frame 0
      for (int n = 0; n < 12; n++)
         pix($sformatf("tbl%0d", n), tbl[n].h, tbl[n].v, tbl[n].draw, tbl[n].idx);

      // Single jump: 1 launch tick, 12 rising, 12 falling
      press();
      tick(1'b0);
      chk("jump.launch_air", 32'(bus.airborne), 32'd1);
      chk("jump.launch_y", 32'(bus.duck_y), 32'd400);
      ticks(12, 1'b0);
      chk("jump.apex_y", 32'(bus.duck_y), 32'd322);
      chk("jump.apex_air", 32'(bus.airborne), 32'd1);
      pix("jump.apex_pix", 200, 322, 1'b1, 4'd2);
      pix("jump.old_row", 200, 400, 1'b0, 4'd0);
      ticks(11, 1'b0);
      chk("jump.fall11_y", 32'(bus.duck_y), 32'd388);
      tick(1'b0);
      chk("jump.land_y", 32'(bus.duck_y), 32'd400);
      chk("jump.land_air", 32'(bus.airborne), 32'd0);

      // Walk animation: toggles on the 8th and 16th idle tick
      ticks(7, 1'b0);
      pix("anim.t7", 200, 400, 1'b1, 4'd2);
      tick(1'b0);
      pix("anim.t8", 200, 400, 1'b1, 4'd3);
      pix("anim.t8_beak", 224, 408, 1'b1, 4'd4);
      ticks(7, 1'b0);
      pix("anim.t15", 200, 400, 1'b1, 4'd3);
      tick(1'b0);
      pix("anim.t16", 200, 400, 1'b1, 4'd2);

      // Button held for 30 frames: exactly one jump
      park(1'b1);
      tick(1'b1);
      chk("hold.first_air", 32'(bus.airborne), 32'd1);
      ticks(29, 1'b1);
      chk("hold.end_air", 32'(bus.airborne), 32'd0);
      chk("hold.end_y", 32'(bus.duck_y), 32'd400);
      park(1'b0);

      // Press while airborne is dropped
      press();
      tick(1'b0);
      chk("air.launch", 32'(bus.airborne), 32'd1);
      ticks(2, 1'b0);
      press();
      ticks(22, 1'b0);
      chk("air.land_air", 32'(bus.airborne), 32'd0);
      chk("air.land_y", 32'(bus.duck_y), 32'd400);
      tick(1'b0);
      chk("air.no_retrig", 32'(bus.airborne), 32'd0);

      // Press in the same clock as the frame tick starts at the next tick
      park(1'b0);
      drive(0, 515, 1'b1);
      drive(10, 520, 1'b1);
      #3;
      chk("same.tick0_air", 32'(bus.airborne), 32'd0);
      park(1'b0);
      tick(1'b0);
      chk("same.tick1_air", 32'(bus.airborne), 32'd1);
      ticks(3, 1'b0);
      chk("same.rise3_y", 32'(bus.duck_y), 32'd367);

      // Reset mid-jump brings the duck straight back to the ground
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      #3;
      chk("mrst.duck_y", 32'(bus.duck_y), 32'd400);
      chk("mrst.airborne", 32'(bus.airborne), 32'd0);
      chk("mrst.draw", 32'(bus.spr_drawing), 32'd0);
      pix("mrst.pix", 200, 400, 1'b1, 4'd2);
      tick(1'b0);
      chk("mrst.no_stale_req", 32'(bus.airborne), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
